// File: rtl/parameter_pkg.sv
// Shared rename-stage parameters and types used by the free list and its neighbours.
package parameter_pkg;

   localparam int unsigned FREE_REG  = 32;
   localparam int unsigned PHY_WIDTH = 6;
   localparam int unsigned ARCH_REGS = 32;

   typedef logic [PHY_WIDTH-1:0] phys_tag_t;

endpackage

// File: rtl/free_list_if.sv
// Rename/commit-side signal bundle for the physical-register free list.
interface free_list_if
   import parameter_pkg::*;
#(
   parameter int unsigned DEPTH = FREE_REG,
   parameter int unsigned TAG_W = PHY_WIDTH
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             alloc_req;
   logic             alloc_valid;
   logic [TAG_W-1:0] alloc_tag;
   logic             free_valid;
   logic [TAG_W-1:0] free_tag;
   logic             commit_alloc;
   logic             flush;
   logic [CNT_W-1:0] free_count;
   logic             overflow_err;

   modport master (
      output alloc_req, free_valid, free_tag, commit_alloc, flush,
      input  alloc_valid, alloc_tag, free_count, overflow_err
   );

   modport slave (
      input  alloc_req, free_valid, free_tag, commit_alloc, flush,
      output alloc_valid, alloc_tag, free_count, overflow_err
   );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with speculative and retired heads.
// Optional same-cycle empty-list bypass of a freed tag: define FREE_LIST_BYPASS_EN.
module free_list
   import parameter_pkg::*;
#(
   parameter int unsigned DEPTH    = FREE_REG,
   parameter int unsigned TAG_W    = PHY_WIDTH,
   parameter int unsigned BASE_TAG = ARCH_REGS
) (
   input logic        clk,
   input logic        rst_n,
   free_list_if.slave fl
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;

   logic [TAG_W-1:0] mem [DEPTH];

   ptr_t spec_head;
   ptr_t retire_head;
   ptr_t tail;
   ptr_t spec_head_nxt;
   ptr_t retire_head_nxt;
   ptr_t tail_nxt;

   logic empty;
   logic full;
   logic bypass_take;
   logic commit_ok;
   logic alloc_fire;
   logic push;
   logic drop;
   logic overflow_q;

   // Slots between retire_head and spec_head are still owned by in-flight
   // instructions, so capacity is measured from retire_head, not spec_head.
   assign empty = (spec_head == tail);
   assign full  = ((tail - retire_head) == ptr_t'(DEPTH));

   always_comb begin
      bypass_take    = 1'b0;
      fl.alloc_valid = !empty && !fl.flush;
      fl.alloc_tag   = mem[spec_head[IDX_W-1:0]];
`ifdef FREE_LIST_BYPASS_EN
      if (empty && fl.free_valid && !fl.flush) begin
         fl.alloc_valid = 1'b1;
         fl.alloc_tag   = fl.free_tag;
         bypass_take    = fl.alloc_req;
      end
`endif
   end

   assign commit_ok  = fl.commit_alloc && (retire_head != spec_head);
   assign alloc_fire = fl.alloc_req && fl.alloc_valid && !bypass_take;
   assign push       = fl.free_valid && !full && !bypass_take;
   assign drop       = fl.free_valid && full && !bypass_take;

   // Flush rewinds to the post-commit retire head so a same-cycle commit is kept.
   assign retire_head_nxt = retire_head + ptr_t'(commit_ok);
   assign spec_head_nxt   = fl.flush ? retire_head_nxt : spec_head + ptr_t'(alloc_fire);
   assign tail_nxt        = tail + ptr_t'(push);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spec_head   <= '0;
         retire_head <= '0;
         tail        <= ptr_t'(DEPTH);
         overflow_q  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= TAG_W'(BASE_TAG + i);
         end
      end else begin
         spec_head   <= spec_head_nxt;
         retire_head <= retire_head_nxt;
         tail        <= tail_nxt;
         if (drop) begin
            overflow_q <= 1'b1;
         end
         if (push) begin
            mem[tail[IDX_W-1:0]] <= fl.free_tag;
         end
      end
   end

   assign fl.free_count   = tail - spec_head;
   assign fl.overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Scenario bench for free_list: a tag queue holds the expected allocation order.
module tb_free_list;
   import parameter_pkg::*;

   localparam int unsigned DEPTH    = FREE_REG;
   localparam int unsigned TAG_W    = PHY_WIDTH;
   localparam int unsigned BASE_TAG = ARCH_REGS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   free_list_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) fl_bus ();

   free_list #(.DEPTH(DEPTH), .TAG_W(TAG_W), .BASE_TAG(BASE_TAG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fl    (fl_bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [TAG_W-1:0] exp_q [$];
   logic [TAG_W-1:0] want;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fl_bus.alloc_req    = 1'b0;
      fl_bus.free_valid   = 1'b0;
      fl_bus.free_tag     = '0;
      fl_bus.commit_alloc = 1'b0;
      fl_bus.flush        = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back(TAG_W'(BASE_TAG + i));
      #1;
   endtask

   // Allocate n tags in consecutive cycles, each checked against the queue head.
   task automatic alloc_n(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         fl_bus.alloc_req = 1'b1;
         #1;
         want = exp_q.pop_front();
         total++;
         if (fl_bus.alloc_valid !== 1'b1 || fl_bus.alloc_tag !== want) begin
            bad++;
            $display("FAIL %s[%0d]: valid=%0b tag=%0d want valid=1 tag=%0d",
                     name, i, fl_bus.alloc_valid, fl_bus.alloc_tag, want);
         end
         tick();
      end
      fl_bus.alloc_req = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (fl_bus.alloc_valid !== 1'b1) begin
         bad++; $display("FAIL reset_valid: got %0b want 1", fl_bus.alloc_valid);
      end
      total++;
      if (fl_bus.alloc_tag !== TAG_W'(BASE_TAG)) begin
         bad++; $display("FAIL reset_tag: got %0d want %0d", fl_bus.alloc_tag, BASE_TAG);
      end
      total++;
      if (fl_bus.free_count !== DEPTH) begin
         bad++; $display("FAIL reset_count: got %0d want %0d", fl_bus.free_count, DEPTH);
      end
      total++;
      if (fl_bus.overflow_err !== 1'b0) begin
         bad++; $display("FAIL reset_ovf: got %0b want 0", fl_bus.overflow_err);
      end
   endtask

   task automatic test_reset_dominant();
      do_reset();
      alloc_n(3, "rd_alloc");
      fl_bus.alloc_req    = 1'b1;
      fl_bus.free_valid   = 1'b1;
      fl_bus.free_tag     = 6'd9;
      fl_bus.commit_alloc = 1'b1;
      fl_bus.flush        = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      total++;
      if (fl_bus.alloc_tag !== TAG_W'(BASE_TAG) || fl_bus.free_count !== DEPTH) begin
         bad++; $display("FAIL rst_dom_state: tag=%0d cnt=%0d want tag=%0d cnt=%0d",
                         fl_bus.alloc_tag, fl_bus.free_count, BASE_TAG, DEPTH);
      end
      total++;
      if (fl_bus.overflow_err !== 1'b0) begin
         bad++; $display("FAIL rst_dom_ovf: got %0b want 0", fl_bus.overflow_err);
      end
   endtask

   task automatic test_drain();
      do_reset();
      alloc_n(int'(DEPTH), "drain");
      total++;
      if (fl_bus.alloc_valid !== 1'b0 || fl_bus.free_count !== 0) begin
         bad++; $display("FAIL drain_empty: valid=%0b cnt=%0d want valid=0 cnt=0",
                         fl_bus.alloc_valid, fl_bus.free_count);
      end
      fl_bus.alloc_req = 1'b1;
      tick();
      fl_bus.alloc_req = 1'b0;
      #1;
      total++;
      if (fl_bus.free_count !== 0) begin
         bad++; $display("FAIL drain_ignore: cnt=%0d want 0", fl_bus.free_count);
      end
   endtask

   // Runs from the empty list left by test_drain.
   task automatic test_free_same_cycle();
      fl_bus.commit_alloc = 1'b1;
      tick();
      fl_bus.commit_alloc = 1'b0;
      fl_bus.free_valid   = 1'b1;
      fl_bus.free_tag     = 6'd5;
      fl_bus.alloc_req    = 1'b1;
      exp_q.push_back(6'd5);
      #1;
`ifdef FREE_LIST_BYPASS_EN
      want = exp_q.pop_front();
      total++;
      if (fl_bus.alloc_valid !== 1'b1 || fl_bus.alloc_tag !== want) begin
         bad++; $display("FAIL bypass_issue: valid=%0b tag=%0d want valid=1 tag=%0d",
                         fl_bus.alloc_valid, fl_bus.alloc_tag, want);
      end
      tick();
      idle();
      #1;
      total++;
      if (fl_bus.free_count !== 0 || fl_bus.alloc_valid !== 1'b0) begin
         bad++; $display("FAIL bypass_after: cnt=%0d valid=%0b want cnt=0 valid=0",
                         fl_bus.free_count, fl_bus.alloc_valid);
      end
`else
      total++;
      if (fl_bus.alloc_valid !== 1'b0) begin
         bad++; $display("FAIL nobypass_valid: got %0b want 0", fl_bus.alloc_valid);
      end
      tick();
      fl_bus.free_valid = 1'b0;
      fl_bus.alloc_req  = 1'b0;
      #1;
      total++;
      if (fl_bus.free_count !== 1) begin
         bad++; $display("FAIL nobypass_count: got %0d want 1", fl_bus.free_count);
      end
      alloc_n(1, "nobypass_alloc");
      total++;
      if (fl_bus.free_count !== 0) begin
         bad++; $display("FAIL nobypass_drain: got %0d want 0", fl_bus.free_count);
      end
`endif
   endtask

   task automatic test_flush_commit();
      do_reset();
      alloc_n(4, "fl_alloc");
      fl_bus.commit_alloc = 1'b1;
      tick();
      fl_bus.commit_alloc = 1'b0;
      fl_bus.flush        = 1'b1;
      #1;
      total++;
      if (fl_bus.alloc_valid !== 1'b0) begin
         bad++; $display("FAIL flush_valid: got %0b want 0", fl_bus.alloc_valid);
      end
      tick();
      fl_bus.flush = 1'b0;
      #1;
      total++;
      if (fl_bus.alloc_tag !== 6'd33 || fl_bus.free_count !== 31) begin
         bad++; $display("FAIL flush_state: tag=%0d cnt=%0d want tag=33 cnt=31",
                         fl_bus.alloc_tag, fl_bus.free_count);
      end
   endtask

   task automatic test_flush_same_commit();
      do_reset();
      alloc_n(3, "fc_alloc");
      fl_bus.flush        = 1'b1;
      fl_bus.commit_alloc = 1'b1;
      tick();
      idle();
      #1;
      total++;
      if (fl_bus.alloc_tag !== 6'd33 || fl_bus.free_count !== 31) begin
         bad++; $display("FAIL fc_state: tag=%0d cnt=%0d want tag=33 cnt=31",
                         fl_bus.alloc_tag, fl_bus.free_count);
      end
      // retire_head == spec_head now, so this commit must be ignored
      fl_bus.commit_alloc = 1'b1;
      tick();
      fl_bus.commit_alloc = 1'b0;
      fl_bus.free_valid   = 1'b1;
      fl_bus.free_tag     = 6'd9;
      tick();
      #1;
      total++;
      if (fl_bus.free_count !== 32 || fl_bus.overflow_err !== 1'b0) begin
         bad++; $display("FAIL fc_free1: cnt=%0d ovf=%0b want cnt=32 ovf=0",
                         fl_bus.free_count, fl_bus.overflow_err);
      end
      fl_bus.free_tag = 6'd10;
      tick();
      idle();
      #1;
      total++;
      if (fl_bus.free_count !== 32 || fl_bus.overflow_err !== 1'b1) begin
         bad++; $display("FAIL fc_free2: cnt=%0d ovf=%0b want cnt=32 ovf=1",
                         fl_bus.free_count, fl_bus.overflow_err);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      fl_bus.free_valid = 1'b1;
      fl_bus.free_tag   = 6'd7;
      tick();
      idle();
      #1;
      total++;
      if (fl_bus.overflow_err !== 1'b1) begin
         bad++; $display("FAIL ovf_set: got %0b want 1", fl_bus.overflow_err);
      end
      total++;
      if (fl_bus.free_count !== DEPTH || fl_bus.alloc_tag !== TAG_W'(BASE_TAG)) begin
         bad++; $display("FAIL ovf_drop: cnt=%0d tag=%0d want cnt=%0d tag=%0d",
                         fl_bus.free_count, fl_bus.alloc_tag, DEPTH, BASE_TAG);
      end
      fl_bus.flush = 1'b1;
      tick();
      idle();
      tick();
      tick();
      total++;
      if (fl_bus.overflow_err !== 1'b1) begin
         bad++; $display("FAIL ovf_sticky: got %0b want 1", fl_bus.overflow_err);
      end
      do_reset();
      total++;
      if (fl_bus.overflow_err !== 1'b0) begin
         bad++; $display("FAIL ovf_clear: got %0b want 0", fl_bus.overflow_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [TAG_W-1:0] ret;
      do_reset();
      alloc_n(2, "b2b_pre");
      fl_bus.commit_alloc = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin
         ret = TAG_W'((i * 13 + 3) % 64);
         fl_bus.alloc_req    = 1'b1;
         fl_bus.commit_alloc = 1'b1;
         fl_bus.free_valid   = 1'b1;
         fl_bus.free_tag     = ret;
         #1;
         want = exp_q.pop_front();
         exp_q.push_back(ret);
         total++;
         if (fl_bus.alloc_valid !== 1'b1 || fl_bus.alloc_tag !== want) begin
            bad++; $display("FAIL b2b_tag[%0d]: valid=%0b tag=%0d want valid=1 tag=%0d",
                            i, fl_bus.alloc_valid, fl_bus.alloc_tag, want);
         end
         tick();
         total++;
         if (fl_bus.free_count !== 30) begin
            bad++; $display("FAIL b2b_count[%0d]: got %0d want 30", i, fl_bus.free_count);
         end
      end
      idle();
      #1;
      total++;
      if (fl_bus.overflow_err !== 1'b0) begin
         bad++; $display("FAIL b2b_ovf: got %0b want 0", fl_bus.overflow_err);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_reset_dominant();
      test_drain();
      test_free_same_cycle();
      test_flush_commit();
      test_flush_same_commit();
      test_overflow();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
